// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Round-robin arbiter sharing one data_memory port between the CPU
//            load/store path (port 0) and the boot/debug loader (port 1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_stall,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [1:0]        ldr_size,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic [31:0]       ldr_rdata,
    output logic              ldr_done,
    output logic              ldr_err,
    output logic              ldr_stall,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam logic       c_port_cpu  = 1'b0;
    localparam logic       c_port_ldr  = 1'b1;
    localparam logic [2:0] c_wait_init = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q,       port_d;
    logic              hold_we_q,    hold_we_d;
    logic [1:0]        hold_size_q,  hold_size_d;
    logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
    logic [31:0]       hold_wdata_q, hold_wdata_d;
    logic [2:0]        wait_cnt_q,   wait_cnt_d;
    logic              cpu_done_q,   cpu_done_d;
    logic              ldr_done_q,   ldr_done_d;
    logic              cpu_err_q,    cpu_err_d;
    logic              ldr_err_q,    ldr_err_d;
    logic [31:0]       cpu_rdata_q,  cpu_rdata_d;
    logic [31:0]       ldr_rdata_q,  ldr_rdata_d;

    logic grant_cpu;
    logic grant_ldr;
    logic misaligned;

    // On a tie the port that did not win last time gets the grant.
    assign grant_cpu = cpu_req & (~ldr_req | (last_grant_q == c_port_ldr));
    assign grant_ldr = ldr_req & ~grant_cpu;

    assign misaligned = ((hold_size_q == 2'b11) && (hold_addr_q[1:0] != 2'b00)) ||
                        ((hold_size_q == 2'b01) && hold_addr_q[0]);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        hold_we_d    = hold_we_q;
        hold_size_d  = hold_size_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        cpu_done_d   = 1'b0;
        ldr_done_d   = 1'b0;
        cpu_err_d    = 1'b0;
        ldr_err_d    = 1'b0;
        cpu_rdata_d  = 32'h0;
        ldr_rdata_d  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (grant_cpu || grant_ldr) begin
                    port_d       = grant_ldr ? c_port_ldr : c_port_cpu;
                    last_grant_d = grant_ldr ? c_port_ldr : c_port_cpu;
                    hold_we_d    = grant_ldr ? ldr_we    : cpu_we;
                    hold_size_d  = grant_ldr ? ldr_size  : cpu_size;
                    hold_addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
                    hold_wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Writes and rejected accesses complete without a data phase.
                if (misaligned || hold_we_q) begin
                    state_d = S_DONE;
                    if (port_q == c_port_cpu) begin
                        cpu_done_d = 1'b1;
                        cpu_err_d  = misaligned;
                    end else begin
                        ldr_done_d = 1'b1;
                        ldr_err_d  = misaligned;
                    end
                end else begin
                    wait_cnt_d = c_wait_init;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    if (port_q == c_port_cpu) begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        ldr_done_d  = 1'b1;
                        ldr_rdata_d = mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= c_port_ldr;
            port_q       <= c_port_cpu;
            hold_we_q    <= 1'b0;
            hold_size_q  <= 2'b00;
            hold_addr_q  <= '0;
            hold_wdata_q <= 32'h0;
            wait_cnt_q   <= 3'd0;
            cpu_done_q   <= 1'b0;
            ldr_done_q   <= 1'b0;
            cpu_err_q    <= 1'b0;
            ldr_err_q    <= 1'b0;
            cpu_rdata_q  <= 32'h0;
            ldr_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            hold_we_q    <= hold_we_d;
            hold_size_q  <= hold_size_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_done_q   <= cpu_done_d;
            ldr_done_q   <= ldr_done_d;
            cpu_err_q    <= cpu_err_d;
            ldr_err_q    <= ldr_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // The holding registers only change on a grant, so the memory bus keeps
    // its last values outside ISSUE; strobes are squashed while in reset.
    assign mem_addr  = hold_addr_q;
    assign mem_wdata = hold_wdata_q;
    assign mem_size  = hold_size_q;
    assign mem_re    = (state_q == S_ISSUE) & ~hold_we_q & ~misaligned & ~reset;
    assign mem_we    = (state_q == S_ISSUE) &  hold_we_q & ~misaligned & ~reset;

    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done_q;

    assign ldr_done  = ldr_done_q;
    assign ldr_err   = ldr_err_q;
    assign ldr_rdata = ldr_rdata_q;
    assign ldr_stall = ldr_req & ~ldr_done_q;

endmodule
`default_nettype wire
